// File: rtl/row_line_buffer_multitap.sv
// row_line_buffer_multitap
// Holds NUM_ROWS image rows of runtime-programmable length in cascaded
// circular memories and, on every accepted push, presents a vertical column
// of NUM_ROWS+1 aligned pixels (slice 0 = newest, slice k = k rows above).
//
// Optional build macro: ROW_LINEBUF_BORDER_REPLICATE_EN
//   defined   : a slice whose sample does not exist yet repeats the slice
//               below it (top-border replication).
//   undefined : such slices drive zero.
module row_line_buffer_multitap #(
  parameter int DATA_W   = 8,
  parameter int MAX_LEN  = 1024,
  parameter int NUM_ROWS = 2,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_load,
  input  logic [LEN_W-1:0]               cfg_len,
  input  logic                           cfg_clear,
  input  logic                           flush,
  input  logic                           push,
  input  logic [DATA_W-1:0]              data_in,
  output logic [(NUM_ROWS+1)*DATA_W-1:0] tap_out,
  output logic                           tap_valid,
  output logic [NUM_ROWS-1:0]            row_full,
  output logic                           window_valid,
  output logic                           no_config,
  output logic                           cfg_error
);

  localparam int PTR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // fill saturates at NUM_ROWS*len+1, so it needs room for that value
  localparam int FILL_W = $clog2(NUM_ROWS * MAX_LEN + 2);

  logic [LEN_W-1:0]  len;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FILL_W-1:0] fill;

  logic [DATA_W-1:0] mem [NUM_ROWS][MAX_LEN];

  logic                           cfg_legal;
  logic                           do_clear;
  logic                           do_load;
  logic                           do_flush;
  logic                           do_push;
  logic                           data_clr;
  logic                           ptr_last;
  logic [FILL_W-1:0]              len_ext;
  logic [FILL_W-1:0]              fill_sat;
  logic [FILL_W-1:0]              fill_inc;
  logic [(NUM_ROWS+1)*DATA_W-1:0] tap_nxt;

  // Control priority: cfg_clear > cfg_load > flush > push; losers are dropped.
  always_comb begin
    cfg_legal = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    do_clear  = cfg_clear;
    do_load   = ~cfg_clear & cfg_load;
    do_flush  = ~cfg_clear & ~cfg_load & flush;
    do_push   = ~cfg_clear & ~cfg_load & ~flush & push & ~no_config;
    data_clr  = do_clear | (do_load & cfg_legal) | do_flush;
    len_ext   = FILL_W'(len);
    fill_sat  = FILL_W'(NUM_ROWS) * len_ext + FILL_W'(1);
    fill_inc  = (fill >= fill_sat) ? fill : fill + FILL_W'(1);
    ptr_last  = (LEN_W'(wr_ptr) == (len - LEN_W'(1)));
  end

  // Next column: slice k exists once more than k*len pixels have been pushed.
  always_comb begin
`ifdef ROW_LINEBUF_BORDER_REPLICATE_EN
    logic [DATA_W-1:0] below;
    below = data_in;
`endif
    tap_nxt = '0;
    tap_nxt[DATA_W-1:0] = data_in;
    for (int k = 1; k <= NUM_ROWS; k++) begin
      if (fill_inc > FILL_W'(k) * len_ext) begin
        tap_nxt[k*DATA_W +: DATA_W] = mem[k-1][wr_ptr];
      end else begin
`ifdef ROW_LINEBUF_BORDER_REPLICATE_EN
        tap_nxt[k*DATA_W +: DATA_W] = below;
`else
        tap_nxt[k*DATA_W +: DATA_W] = '0;
`endif
      end
`ifdef ROW_LINEBUF_BORDER_REPLICATE_EN
      below = tap_nxt[k*DATA_W +: DATA_W];
`endif
    end
  end

  // Row memories: read-before-write cascade, each row shifts one row down.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[0][wr_ptr] <= data_in;
      for (int k = 1; k < NUM_ROWS; k++) begin
        mem[k][wr_ptr] <= mem[k-1][wr_ptr];
      end
    end
  end

  // Configuration, write pointer, fill count and registered tap column.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len       <= '0;
      no_config <= 1'b1;
      wr_ptr    <= '0;
      fill      <= '0;
      tap_out   <= '0;
      tap_valid <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      tap_valid <= do_push;
      cfg_error <= do_load & ~cfg_legal;
      if (do_clear) begin
        len       <= '0;
        no_config <= 1'b1;
      end else if (do_load && cfg_legal) begin
        len       <= cfg_len;
        no_config <= 1'b0;
      end
      if (data_clr) begin
        wr_ptr  <= '0;
        fill    <= '0;
        tap_out <= '0;
      end else if (do_push) begin
        wr_ptr  <= ptr_last ? '0 : wr_ptr + PTR_W'(1);
        fill    <= fill_inc;
        tap_out <= tap_nxt;
      end
    end
  end

  // Fill flags are derived from the push count; gated so len=0 never reads as full.
  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_row_full
    assign row_full[k] = ~no_config & (fill >= FILL_W'(k + 1) * len_ext);
  end

  assign window_valid = ~no_config & (fill >= fill_sat);

endmodule
